muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, alongside the ALU.
- Owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exposes HI/LO for MFHI/MFLO forwarding, and raises a stall to the hazard unit while an operation is in flight.

Parameters:
- DATA_W, 32: operand, HI and LO width.
- CNT_W, 5: iteration counter width; must satisfy 2**CNT_W >= DATA_W.

Ports:
- i_clk, input, 1: single clock. All state updates on the rising edge.
- i_rst_n, input, 1: reset, synchronous and active-low.
- i_con_Valid, input, 1: the EX-stage instruction is a mul/div-class op (includes MFHI/MFLO).
- i_con_MdOp, input, 3: operation code, qualified by i_con_Valid; encoding in arc_pkg.
- i_data_A, input, DATA_W: rs operand (dividend / multiplicand / MTHI/MTLO source).
- i_data_B, input, DATA_W: rt operand (divisor / multiplier).
- o_data_Hi, output, DATA_W: HI register.
- o_data_Lo, output, DATA_W: LO register.
- o_con_Busy, output, 1: iteration in progress.
- o_con_Stall, output, 1: hold IF/ID/EX; combinational, equal to o_con_Busy & i_con_Valid.

Behaviour:
- Reset (i_rst_n=0 at a clock edge) gives:
  - state=IDLE, HI=0, LO=0, counter=0, o_con_Busy=0;
  - all internal operand/accumulator registers cleared;
  - an in-flight operation is abandoned with no HI/LO write.
- States and transitions:
  - IDLE -> RUN, when i_con_Valid with op in {MULT, MULTU, DIV, DIVU}:
    - latch |A| and |B| for signed ops (raw values for unsigned);
    - latch result-sign flags: qsign = A[31]^B[31] and rsign = A[31], forced to 0 for unsigned ops;
    - counter=0.
  - RUN: one iteration per cycle, counter increments; after the iteration at counter=DATA_W-1, go to FIX.
    - Multiply: shift-add; 64-bit accumulator {hi_acc, lo_acc}; add the multiplicand to the upper half when the multiplier LSB is 1; shift right 1.
    - Divide: restoring; remainder shifts left taking the dividend MSB; trial-subtract the divisor; quotient bit = no borrow.
  - FIX, one cycle, then -> IDLE:
    - Multiply: negate the 64-bit product if qsign; HI=upper, LO=lower.
    - Divide: LO = quotient, negated if qsign; HI = remainder, negated if rsign.
- Latency:
  - A start accepted at edge N gives o_con_Busy=1 from N+1 to N+DATA_W+1 inclusive (33 cycles for DATA_W=32).
  - HI/LO update at edge N+DATA_W+1.
  - o_con_Busy=0 after N+DATA_W+1.
- MTHI/MTLO in IDLE: HI or LO = i_data_A at the next edge, no busy cycle.
- MFHI/MFLO: no state change; the datapath selects o_data_Hi/o_data_Lo.
- Any i_con_Valid while busy (MF*, MT*, or a new start) asserts o_con_Stall. The op is not accepted and is retried once busy drops; no queueing.
- Divide by zero:
  - runs the full latency;
  - result LO=32'hFFFFFFFF and HI=dividend (raw i_data_A), for signed and unsigned alike;
  - sign fix is not applied.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of magnitude arithmetic; no special case.
- HI/LO hold their values except on a FIX, MTHI/MTLO or reset edge.
- Start in the same cycle that FIX completes: impossible, since busy is still 1 during FIX; the start stalls one more cycle.

Decomposition:
- arc_pkg (shared) holds:
  - typedef enum logic [2:0] md_op_e: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5, MD_MFHI=6, MD_MFLO=7;
  - typedef enum logic [1:0] md_state_e: IDLE, RUN, FIX.
- The main decoder and hazard unit use the same enum.
- One natural sub-module: md_signfix, a combinational conditional two's-complement negate, parameterised by width. It is instantiated for the operand abs (32-bit), the product (64-bit) and the quotient/remainder (32-bit).

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=5 -> after 33 busy cycles: HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy exactly 33 cycles.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV 1234/0 -> LO=0xFFFFFFFF, HI=1234 after full latency.
- Start MULT 6*7, assert MFLO valid the next cycle -> o_con_Stall=1 for the full busy window, then LO=42 visible the cycle busy drops. MTLO 0x55 during busy is held off and applied after the multiply result.
- Start DIVU, drive i_rst_n=0 at iteration 10 -> next edge: busy=0, HI=LO=0. A new MULT 2*3 then gives LO=6.

Source files
------------

// File: rtl/arc_pkg.sv
// arc_pkg: shared opcode and state encodings for the multiply/divide path
package arc_pkg;
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MFHI  = 3'd6,
    MD_MFLO  = 3'd7
  } md_op_e;
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } md_state_e;
endpackage

// File: rtl/md_signfix.sv
// md_signfix: conditional two's-complement negate
module md_signfix #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);
  assign o_data = i_neg ? -i_data : i_data;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider owning HI and LO
module muldiv_unit
  import arc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_con_Valid,
  input  logic [2:0]        i_con_MdOp,
  input  logic [DATA_W-1:0] i_data_A,
  input  logic [DATA_W-1:0] i_data_B,
  output logic [DATA_W-1:0] o_data_Hi,
  output logic [DATA_W-1:0] o_data_Lo,
  output logic              o_con_Busy,
  output logic              o_con_Stall
);
  md_state_e state, state_nx;
  md_op_e op;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] hi_acc, lo_acc, opnd, abs_a, abs_b, quo, rem, mul_lo, div_hi, div_lo;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W:0] add_sum, shl, diff;
  logic is_div, qsign, rsign, start, sgn, div_op, dz, last, idle;
  assign op          = md_op_e'(i_con_MdOp);
  assign idle        = state == IDLE;
  assign o_con_Busy  = !idle;
  assign o_con_Stall = o_con_Busy & i_con_Valid;
  assign start       = i_con_Valid && idle && (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU);
  assign sgn         = op == MD_MULT || op == MD_DIV;
  assign div_op      = op == MD_DIV || op == MD_DIVU;
  // A zero divisor runs unsigned on the raw dividend so the remainder ends up equal to it
  assign dz          = div_op && i_data_B == '0;
  assign last        = cnt == CNT_W'(DATA_W - 1);
  md_signfix #(.W(DATA_W)) u_abs_a (
    .i_neg  (sgn & i_data_A[DATA_W-1] & ~dz),
    .i_data (i_data_A),
    .o_data (abs_a)
  );
  md_signfix #(.W(DATA_W)) u_abs_b (
    .i_neg  (sgn & i_data_B[DATA_W-1]),
    .i_data (i_data_B),
    .o_data (abs_b)
  );
  md_signfix #(.W(2*DATA_W)) u_prod (
    .i_neg  (qsign),
    .i_data ({hi_acc, lo_acc}),
    .o_data (prod)
  );
  md_signfix #(.W(DATA_W)) u_quo (
    .i_neg  (qsign),
    .i_data (lo_acc),
    .o_data (quo)
  );
  md_signfix #(.W(DATA_W)) u_rem (
    .i_neg  (rsign),
    .i_data (hi_acc),
    .o_data (rem)
  );
  // One multiply or divide step on the accumulator pair
  always_comb begin
    add_sum = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, opnd} : '0);
    shl     = {hi_acc, lo_acc[DATA_W-1]};
    diff    = shl - {1'b0, opnd};
    mul_lo  = {add_sum[0], lo_acc[DATA_W-1:1]};
    div_hi  = diff[DATA_W] ? shl[DATA_W-1:0] : diff[DATA_W-1:0];
    div_lo  = {lo_acc[DATA_W-2:0], ~diff[DATA_W]};
  end
  // Next-state: accept a start in IDLE, iterate DATA_W times, one FIX cycle
  always_comb begin
    state_nx = state;
    state_nx = idle ? (start ? RUN : IDLE) : state == RUN ? (last ? FIX : RUN) : IDLE;
  end
  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // Operand latch and iteration registers; multiply keeps multiplier in lo_acc, divide keeps dividend there
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      hi_acc <= '0;
      lo_acc <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      qsign  <= 1'b0;
      rsign  <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      hi_acc <= '0;
      lo_acc <= div_op ? abs_a : abs_b;
      opnd   <= div_op ? abs_b : abs_a;
      is_div <= div_op;
      qsign  <= sgn & ~dz & (i_data_A[DATA_W-1] ^ i_data_B[DATA_W-1]);
      rsign  <= sgn & ~dz & i_data_A[DATA_W-1];
    end else if (state == RUN) begin
      cnt    <= cnt + CNT_W'(1);
      hi_acc <= is_div ? div_hi : add_sum[DATA_W:1];
      lo_acc <= is_div ? div_lo : mul_lo;
    end
  end
  // HI/LO: written by the FIX cycle or by an MTHI/MTLO taken in IDLE
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_data_Hi <= '0;
      o_data_Lo <= '0;
    end else if (state == FIX) begin
      o_data_Hi <= is_div ? rem : prod[2*DATA_W-1:DATA_W];
      o_data_Lo <= is_div ? quo : prod[DATA_W-1:0];
    end else if (i_con_Valid && idle) begin
      o_data_Hi <= op == MD_MTHI ? i_data_A : o_data_Hi;
      o_data_Lo <= op == MD_MTLO ? i_data_A : o_data_Lo;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random scoreboard checks of the multiply/divide unit
module tb_muldiv_unit;
  import arc_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [2:0]  mdop = 3'd0;
  logic [31:0] da = '0, db = '0;
  logic [31:0] hi, lo;
  logic        busy, stall;
  logic [63:0] sb[$];
  int          n_vec = 0, n_bad = 0;
  int          n, stall_bad;
  logic [31:0] ra, rb;
  logic signed [63:0] sp;
  muldiv_unit dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_con_Valid (valid),
    .i_con_MdOp  (mdop),
    .i_data_A    (da),
    .i_data_B    (db),
    .o_data_Hi   (hi),
    .o_data_Lo   (lo),
    .o_con_Busy  (busy),
    .o_con_Stall (stall)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int k;
    sb.push_back(exp);
    valid = 1'b1;
    mdop = op;
    da = a;
    db = b;
    step();
    valid = 1'b0;
    k = 0;
    while (busy && k < 100) begin
      k++;
      step();
    end
    check({tag, "_busy"}, 64'(k), 64'd33);
    check(tag, {hi, lo}, sb.pop_front());
  endtask
  initial begin
    step();
    step();
    valid = 1'b1;
    mdop = MD_MFLO;
    #1;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    valid = 1'b0;
    rst_n = 1'b1;
    step();
    run_op("mult_neg", MD_MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
    run_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    run_op("div_m7_2", MD_DIV, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
    run_op("div_zero", MD_DIV, 32'd1234, 32'd0, {32'd1234, 32'hFFFFFFFF});
    run_op("div_zero_neg", MD_DIV, 32'hFFFFFFF0, 32'd0, {32'hFFFFFFF0, 32'hFFFFFFFF});
    run_op("divu_zero", MD_DIVU, 32'h87654321, 32'd0, {32'h87654321, 32'hFFFFFFFF});
    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op("rnd_multu", MD_MULTU, ra, rb, 64'(ra) * 64'(rb));
      sp = 64'($signed(ra)) * 64'($signed(rb));
      run_op("rnd_mult", MD_MULT, ra, rb, sp);
      rb = rb >> $urandom_range(0, 31);
      if (rb == 0) rb = 32'd1;
      run_op("rnd_divu", MD_DIVU, ra, rb, {ra % rb, ra / rb});
    end
    valid = 1'b1;
    mdop = MD_MTHI;
    da = 32'hDEADBEEF;
    #1;
    check("mthi_nostall", {63'd0, stall}, 64'd0);
    step();
    valid = 1'b0;
    check("mthi_busy", {63'd0, busy}, 64'd0);
    check("mthi_hi", {32'd0, hi}, {32'd0, 32'hDEADBEEF});
    sb.push_back({32'd0, 32'd42});
    valid = 1'b1;
    mdop = MD_MULT;
    da = 32'd6;
    db = 32'd7;
    step();
    mdop = MD_MFLO;
    n = 0;
    stall_bad = 0;
    while (busy && n < 100) begin
      if (!stall) stall_bad++;
      n++;
      step();
    end
    check("mflo_window", 64'(n), 64'd33);
    check("mflo_stall_held", 64'(stall_bad), 64'd0);
    check("mflo_stall_drop", {63'd0, stall}, 64'd0);
    check("mflo_lo", {hi, lo}, sb.pop_front());
    valid = 1'b0;
    sb.push_back({32'd0, 32'd42});
    valid = 1'b1;
    mdop = MD_MULT;
    da = 32'd6;
    db = 32'd7;
    step();
    mdop = MD_MTLO;
    da = 32'h55;
    n = 0;
    stall_bad = 0;
    while (busy && n < 100) begin
      if (!stall) stall_bad++;
      n++;
      step();
    end
    check("mtlo_stall_held", 64'(stall_bad), 64'd0);
    check("mtlo_held_off", {hi, lo}, sb.pop_front());
    sb.push_back({32'd0, 32'h55});
    step();
    valid = 1'b0;
    check("mtlo_applied", {hi, lo}, sb.pop_front());
    check("mtlo_busy", {63'd0, busy}, 64'd0);
    valid = 1'b1;
    mdop = MD_DIVU;
    da = 32'd1000;
    db = 32'd3;
    step();
    valid = 1'b0;
    repeat (10) step();
    check("abort_busy_pre", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    step();
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    step();
    check("abort_idle", {63'd0, busy}, 64'd0);
    run_op("post_rst_mult", MD_MULT, 32'd2, 32'd3, 64'd6);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
